sobel_stream: RTL and testbench
===============================

SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 Parameter: IMG_W, 512, pixels per line, 4..4096.
REQ-002 Parameter: IMG_H, 512, lines per frame, 3..4096.
REQ-003 Parameter: CH_W, 8, bits per colour channel.
REQ-004 Parameter: OUT_DEPTH, 4, output FIFO entries, at least 2.
REQ-005 Port: i_clk  in  1  sole clock; all logic SHALL be on the rising edge.
REQ-006 Port: i_rst  in  1  reset, synchronous and active-high.
REQ-007 Port: i_mode  in  2  result select: 0 = |Gx|+|Gy|, 1 = |Gx|, 2 = |Gy|, 3 = grayscale pass-through.
REQ-008 Port: i_rgb_vld  in  1  input pixel valid.
REQ-009 Port: i_rgb_data  in  32  R in [CH_W-1:0], G in [2*CH_W-1:CH_W], B in [3*CH_W-1:2*CH_W]; upper bits ignored.
REQ-010 Port: i_rgb_busy  out  1  the block cannot accept input.
REQ-011 Port: o_result_busy  in  1  the sink cannot accept output.
REQ-012 Port: o_result_vld  out  1  result valid.
REQ-013 Port: o_result_data  out  32  result, zero-extended from bit CH_W+3.

Function
REQ-014 Input transfer SHALL occur on a cycle with i_rgb_vld=1 and i_rgb_busy=0; output transfer SHALL occur on a cycle with o_result_vld=1 and o_result_busy=0.
REQ-015 Gray SHALL be computed as (R + 2G + B) >> 2, exact and unrounded, CH_W bits wide.
REQ-016 Column counter col and row counter row SHALL advance once per input transfer, raster order; col wraps IMG_W-1 to 0 and increments row; row wraps IMG_H-1 to 0, starting a new frame.
REQ-017 Two line buffers of IMG_W x CH_W SHALL hold the previous two gray lines; a 3x3 window register SHALL shift on each input transfer.
REQ-018 A window SHALL be emitted only on an accepted pixel with row>=2 and col>=2, centred at (row-1, col-1); the block SHALL emit exactly (IMG_W-2)*(IMG_H-2) results per frame with no border outputs.
REQ-019 Gx = (p02+2*p12+p22) - (p00+2*p10+p20) and Gy = (p20+2*p21+p22) - (p00+2*p01+p02) SHALL be signed CH_W+3 bits; the absolute values SHALL be unsigned; the sum SHALL be CH_W+3 bits and never saturate.
REQ-020 Mode 3 SHALL output the window centre gray value p11.
REQ-021 i_mode SHALL be sampled on the first input transfer of each frame (row=0, col=0) and held for that frame.
REQ-022 Latency: the result SHALL be presented on o_result_vld 2 cycles after the triggering input transfer, provided the FIFO is empty (1 compute register stage, then a FIFO write).
REQ-023 The output FIFO SHALL hold OUT_DEPTH entries, first-in first-out; a simultaneous push and pop SHALL keep the count unchanged.
REQ-024 i_rgb_busy SHALL be 1 when FIFO count >= OUT_DEPTH-1, so that the single in-flight result is never dropped; no result SHALL ever be lost or duplicated.
REQ-025 o_result_data SHALL hold steady while o_result_vld=1 and o_result_busy=1.

Reset
REQ-026 While i_rst=1: i_rgb_busy=1, o_result_vld=0, o_result_data=0, counters=0, FIFO empty, compute stage empty, latched mode=0.
REQ-027 Line-buffer contents are not reset; no window using stale data SHALL be emitted, because of REQ-018.
REQ-028 Reset asserted mid-frame SHALL discard all partial-frame and queued results; the first pixel after reset is (0,0).
REQ-029 i_rgb_busy SHALL fall in the cycle after i_rst deasserts.

Structure
REQ-030 A shared package sobel_pkg SHALL hold the mode enumeration and the packing and field-offset constants.
REQ-031 A single sub-module line_buffer (a parametrised depth x width single-port delay line, one read and one write per accepted pixel) SHALL be instantiated twice.
REQ-032 The FIFO, counters, window and arithmetic SHALL be in sobel_stream.

Verification (IMG_W=8, IMG_H=6, CH_W=8 unless stated)
REQ-033 Constant image with R=G=B=100, mode 0 -> 24 results, all 0.
REQ-034 Vertical edge: columns 0-3 have R=G=B=0, columns 4-7 have 255, mode 0 -> each row of 6 results reads 0,0,1020,1020,0,0; mode 2 -> all 0.
REQ-035 Mode 3 with pixel R=40, G=80, B=120 everywhere -> all 24 results are 80.
REQ-036 o_result_busy held high for 20 cycles mid-frame -> i_rgb_busy rises when the count reaches 3; after release, results are in order with the count still totalling 24.
REQ-037 i_rst pulsed after 30 input pixels, then a full frame sent -> exactly 24 results, none from the aborted frame.
REQ-038 Two back-to-back frames, mode 1 then mode 0, with i_mode changed mid-frame 1 -> frame 1 is all mode 1, frame 2 is all mode 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel streaming filter: result modes and bus packing.
package sobel_pkg;

  // Result select, sampled once per frame
  typedef enum logic [1:0] {
    ModeSum  = 2'd0,
    ModeGx   = 2'd1,
    ModeGy   = 2'd2,
    ModeGray = 2'd3
  } mode_e;

  // Width of the pixel and result buses
  localparam int unsigned BUS_W     = 32;
  // Channel slots in i_rgb_data, in units of CH_W
  localparam int unsigned R_IDX     = 0;
  localparam int unsigned G_IDX     = 1;
  localparam int unsigned B_IDX     = 2;
  // Gradient results need CH_W + 3 bits (signed range of +/-4*max)
  localparam int unsigned RES_EXTRA = 3;

endpackage

// File: rtl/sobel_stream_if.sv
// Pixel-in / result-out handshake bundle for sobel_stream.
interface sobel_stream_if;
  import sobel_pkg::*;

  logic [1:0]       i_mode;
  logic             i_rgb_vld;
  logic [BUS_W-1:0] i_rgb_data;
  logic             i_rgb_busy;
  logic             o_result_busy;
  logic             o_result_vld;
  logic [BUS_W-1:0] o_result_data;

  // Filter side
  modport slave (
    input  i_mode, i_rgb_vld, i_rgb_data, o_result_busy,
    output i_rgb_busy, o_result_vld, o_result_data
  );

  // Source/sink side
  modport master (
    output i_mode, i_rgb_vld, i_rgb_data, o_result_busy,
    input  i_rgb_busy, o_result_vld, o_result_data
  );

endinterface

// File: rtl/line_buffer.sv
// Single-port line delay: read-before-write at the same address, one access per pixel.
module line_buffer #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  // Contents are deliberately not reset; stale lines never reach an emitted window
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Returns the value stored one line ago at this column
  assign o_rdata = r_mem[i_addr];

  // Overwrite the column with the current line's value
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel filter: RGB -> gray, two line buffers, window, one compute stage, FIFO.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W     = 512,
  parameter int unsigned IMG_H     = 512,
  parameter int unsigned CH_W      = 8,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  sobel_stream_if.slave  io_bus
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned RES_W = CH_W + RES_EXTRA;
  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  mode_e            r_mode;
  logic             r_rst_d;
  logic [CH_W-1:0]  r_win [3][2];
  logic [CH_W-1:0]  w_p [3][3];
  logic             r_s1_vld;
  logic [RES_W-1:0] r_s1_data;
  logic [RES_W-1:0] r_mem [OUT_DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_cnt;

  logic             w_busy, w_acc, w_emit, w_col_last, w_row_last, w_out_vld, w_pop;
  logic [CH_W-1:0]  w_r, w_g, w_b, w_gray, w_lb_mid, w_lb_top;
  logic [CH_W+1:0]  w_gray_sum, w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic signed [RES_W-1:0] w_gx, w_gy;
  logic [RES_W-1:0] w_gx_abs, w_gy_abs, w_sum, w_result;
  logic             w_unused_bits;

  assign w_r = io_bus.i_rgb_data[R_IDX*CH_W +: CH_W];
  assign w_g = io_bus.i_rgb_data[G_IDX*CH_W +: CH_W];
  assign w_b = io_bus.i_rgb_data[B_IDX*CH_W +: CH_W];
  assign w_unused_bits = ^io_bus.i_rgb_data[BUS_W-1:3*CH_W];

  assign w_gray_sum = {2'b00, w_r} + {1'b0, w_g, 1'b0} + {2'b00, w_b};
  assign w_gray     = w_gray_sum[CH_W+1:2];

  // Busy covers reset, the cycle after it, and the FIFO slot kept free for the in-flight result
  assign w_busy     = i_rst | r_rst_d | (r_cnt >= CNT_W'(OUT_DEPTH - 1));
  assign w_acc      = io_bus.i_rgb_vld & ~w_busy;
  assign w_col_last = (r_col == COL_W'(IMG_W - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
  assign w_emit     = w_acc && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

  // Delays the busy release by one cycle after reset
  always_ff @(posedge i_clk) begin
    r_rst_d <= i_rst;
  end

  // Raster position, advanced once per accepted pixel
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Mode is latched on the first pixel of a frame and held until the next one
  always_ff @(posedge i_clk) begin
    if (i_rst) r_mode <= ModeSum;
    else if (w_acc && r_row == '0 && r_col == '0) r_mode <= mode_e'(io_bus.i_mode);
  end

  line_buffer #(.DEPTH(IMG_W), .WIDTH(CH_W), .ADDR_W(COL_W)) u_lb_mid (
    .i_clk   (i_clk),
    .i_we    (w_acc),
    .i_addr  (r_col),
    .i_wdata (w_gray),
    .o_rdata (w_lb_mid)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(CH_W), .ADDR_W(COL_W)) u_lb_top (
    .i_clk   (i_clk),
    .i_we    (w_acc),
    .i_addr  (r_col),
    .i_wdata (w_lb_mid),
    .o_rdata (w_lb_top)
  );

  // Full window: two stored columns plus the column arriving with this pixel
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_p[r][0] = r_win[r][0];
      w_p[r][1] = r_win[r][1];
    end
    w_p[0][2] = w_lb_top;
    w_p[1][2] = w_lb_mid;
    w_p[2][2] = w_gray;
  end

  // Shift the window one column left on every accepted pixel
  always_ff @(posedge i_clk) begin
    if (w_acc) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= w_p[r][2];
      end
    end
  end

  // Gradients and mode-selected result
  always_comb begin
    w_gx_pos = {2'b00, w_p[0][2]} + {1'b0, w_p[1][2], 1'b0} + {2'b00, w_p[2][2]};
    w_gx_neg = {2'b00, w_p[0][0]} + {1'b0, w_p[1][0], 1'b0} + {2'b00, w_p[2][0]};
    w_gy_pos = {2'b00, w_p[2][0]} + {1'b0, w_p[2][1], 1'b0} + {2'b00, w_p[2][2]};
    w_gy_neg = {2'b00, w_p[0][0]} + {1'b0, w_p[0][1], 1'b0} + {2'b00, w_p[0][2]};
    w_gx     = $signed({1'b0, w_gx_pos}) - $signed({1'b0, w_gx_neg});
    w_gy     = $signed({1'b0, w_gy_pos}) - $signed({1'b0, w_gy_neg});
    w_gx_abs = w_gx[RES_W-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
    w_gy_abs = w_gy[RES_W-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
    w_sum    = w_gx_abs + w_gy_abs;
    w_result = w_sum;
    unique case (r_mode)
      ModeSum:  w_result = w_sum;
      ModeGx:   w_result = w_gx_abs;
      ModeGy:   w_result = w_gy_abs;
      ModeGray: w_result = {{RES_EXTRA{1'b0}}, w_p[1][1]};
    endcase
  end

  // Single compute register stage between the window and the FIFO
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= w_emit;
      if (w_emit) r_s1_data <= w_result;
    end
  end

  assign w_out_vld = (r_cnt != '0) & ~i_rst;
  assign w_pop     = w_out_vld & ~io_bus.o_result_busy;

  // FIFO pointers and occupancy; push comes straight from the compute stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (r_s1_vld) r_wr <= (r_wr == PTR_W'(OUT_DEPTH - 1)) ? '0 : r_wr + PTR_W'(1);
      if (w_pop)    r_rd <= (r_rd == PTR_W'(OUT_DEPTH - 1)) ? '0 : r_rd + PTR_W'(1);
      if (r_s1_vld && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (!r_s1_vld && w_pop) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // FIFO storage; the head entry is never overwritten while occupied
  always_ff @(posedge i_clk) begin
    if (r_s1_vld) r_mem[r_wr] <= r_s1_data;
  end

  assign io_bus.i_rgb_busy    = w_busy;
  assign io_bus.o_result_vld  = w_out_vld;
  assign io_bus.o_result_data = w_out_vld ? {{(BUS_W - RES_W){1'b0}}, r_mem[r_rd]} : '0;

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream on an 8x6 image with a frame-level reference model.
module tb_sobel_stream;

  localparam int W     = 8;
  localparam int H     = 6;
  localparam int CW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_stream_if bus ();

  sobel_stream #(.IMG_W(W), .IMG_H(H), .CH_W(CW), .OUT_DEPTH(DEPTH)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [31:0] img [H][W];
  int          exp_q [$];
  logic [31:0] got_q [$];
  int          hold_left  = 0;
  int          hold_acc   = 0;
  int          n_timeouts = 0;
  bit          busy_seen  = 0;

  // Capture every output transfer
  always @(negedge clk) begin
    if (bus.o_result_vld === 1'b1 && bus.o_result_busy === 1'b0) got_q.push_back(bus.o_result_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gray(input logic [31:0] p);
    return (int'(p[7:0]) + 2 * int'(p[15:8]) + int'(p[23:16])) >> 2;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected results for the current image: every interior pixel, raster order
  function automatic void model_frame(input int mode);
    int g [H][W];
    int gx, gy;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) g[y][x] = gray(img[y][x]);
    for (int y = 1; y < H - 1; y++) begin
      for (int x = 1; x < W - 1; x++) begin
        gx = (g[y-1][x+1] + 2 * g[y][x+1] + g[y+1][x+1])
           - (g[y-1][x-1] + 2 * g[y][x-1] + g[y+1][x-1]);
        gy = (g[y+1][x-1] + 2 * g[y+1][x] + g[y+1][x+1])
           - (g[y-1][x-1] + 2 * g[y-1][x] + g[y-1][x+1]);
        case (mode)
          0:       exp_q.push_back(iabs(gx) + iabs(gy));
          1:       exp_q.push_back(iabs(gx));
          2:       exp_q.push_back(iabs(gy));
          default: exp_q.push_back(g[y][x]);
        endcase
      end
    end
  endfunction

  function automatic void fill_const(input int r, input int g, input int b);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = {8'($urandom), 8'(b), 8'(g), 8'(r)};
  endfunction

  function automatic void fill_vedge();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = (x < 4) ? 32'h0 : 32'h00FF_FFFF;
  endfunction

  function automatic void fill_random();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = $urandom;
  endfunction

  // Starts and ends at posedge+1; waits out input back-pressure with a bound
  task automatic send_pixel(input logic [31:0] d);
    int  guard;
    bit  accepted;
    guard = 0;
    bus.i_rgb_vld  = 1'b1;
    bus.i_rgb_data = d;
    do begin
      @(negedge clk);
      accepted = (bus.i_rgb_busy === 1'b0);
      if (bus.o_result_busy === 1'b1) begin
        if (accepted) hold_acc++;
        else busy_seen = 1'b1;
      end
      @(posedge clk);
      #1;
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) bus.o_result_busy = 1'b0;
      end
      guard++;
    end while (!accepted && guard < 500);
    if (!accepted) n_timeouts++;
    bus.i_rgb_vld = 1'b0;
  endtask

  task automatic send_frame(input int n_pix, input int hold_at, input int sw_at,
                            input logic [1:0] sw_mode);
    for (int k = 0; k < n_pix; k++) begin
      if (k == hold_at) begin
        bus.o_result_busy = 1'b1;
        hold_left = 20;
        hold_acc  = 0;
        busy_seen = 1'b0;
      end
      if (k == sw_at) bus.i_mode = sw_mode;
      send_pixel(img[k / W][k % W]);
    end
  endtask

  task automatic wait_results(input int n);
    int guard;
    guard = 0;
    while (got_q.size() < n && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 400) n_timeouts++;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic compare_results(input string tag);
    check({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_rgb_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", bus.i_rgb_busy, 1);
    check("rst vld", bus.o_result_vld, 0);
    check("rst data", bus.o_result_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("busy first cycle after rst", bus.i_rgb_busy, 1);
    @(negedge clk);
    check("busy released", bus.i_rgb_busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pat [6];
    logic [1:0] m;
    pat = '{0, 0, 1020, 1020, 0, 0};
    bus.i_mode        = 2'd0;
    bus.i_rgb_vld     = 1'b0;
    bus.i_rgb_data    = '0;
    bus.o_result_busy = 1'b0;
    rst = 1'b1;
    do_reset();

    // Flat image gives zero gradient
    fill_const(100, 100, 100);
    bus.i_mode = 2'd0;
    model_frame(0);
    send_frame(W * H, -1, -1, 2'd0);
    wait_results(24);
    for (int i = 0; i < got_q.size(); i++) check("const zero", got_q[i], 0);
    compare_results("const");

    // Vertical edge, magnitude sum then vertical gradient only
    fill_vedge();
    model_frame(0);
    send_frame(W * H, -1, -1, 2'd0);
    wait_results(24);
    for (int i = 0; i < got_q.size(); i++) check("vedge pattern", got_q[i], pat[i % 6]);
    compare_results("vedge m0");
    bus.i_mode = 2'd2;
    model_frame(2);
    send_frame(W * H, -1, -1, 2'd0);
    wait_results(24);
    compare_results("vedge m2");

    // Gray pass-through
    fill_const(40, 80, 120);
    bus.i_mode = 2'd3;
    model_frame(3);
    send_frame(W * H, -1, -1, 2'd0);
    wait_results(24);
    for (int i = 0; i < got_q.size(); i++) check("gray 80", got_q[i], 80);
    compare_results("gray");

    // Random images in every mode
    for (int md = 0; md < 4; md++) begin
      fill_random();
      bus.i_mode = 2'(md);
      model_frame(md);
      send_frame(W * H, -1, -1, 2'd0);
      wait_results(24);
      compare_results($sformatf("rand m%0d", md));
    end

    // Sink stalls for 20 cycles starting at row 3 col 2 with an empty FIFO
    fill_random();
    m = 2'($urandom_range(0, 3));
    bus.i_mode = m;
    model_frame(int'(m));
    send_frame(W * H, 26, -1, 2'd0);
    check("stall accepted", hold_acc, DEPTH);
    check("stall busy seen", 32'(busy_seen), 1);
    wait_results(24);
    compare_results("stall");

    // Abort after 30 pixels with results queued, then a clean frame
    fill_random();
    bus.i_mode = 2'($urandom_range(0, 3));
    send_frame(30, 26, -1, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    got_q.delete();
    hold_left = 0;
    rst = 1'b1;
    bus.o_result_busy = 1'b0;
    do_reset();
    check("abort no leftovers", got_q.size(), 0);
    fill_random();
    m = 2'($urandom_range(0, 3));
    bus.i_mode = m;
    model_frame(int'(m));
    send_frame(W * H, -1, -1, 2'd0);
    wait_results(24);
    compare_results("after abort");

    // Back-to-back frames; mode change mid-frame takes effect on the next frame only
    fill_random();
    bus.i_mode = 2'd1;
    model_frame(1);
    send_frame(W * H, -1, 20, 2'd0);
    fill_random();
    model_frame(0);
    send_frame(W * H, -1, -1, 2'd0);
    wait_results(48);
    compare_results("b2b");

    check("timeouts", n_timeouts, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
